// File: rtl/div_repsub.sv
// div_repsub: sequential unsigned divider by repeated subtraction.
// Dividend and divisor arrive on the shared data_in bus in the two cycles after
// start is accepted. One compare/subtract is done per clock while CALC is active.
// Optional build macro: DIV_ABORT_EN adds an abort input that cancels a running
// division (LDA, LDB or CALC) and returns to IDLE with cleared results.
module div_repsub #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef DIV_ABORT_EN
    input  logic         abort,
`endif
    input  logic [W-1:0] data_in,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         dbz
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDA  = 3'd1,
        ST_LDB  = 3'd2,
        ST_CALC = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t         state_r;
    state_t         next_state_s;

    logic [W-1:0]   q_r;        // quotient accumulator
    logic [W-1:0]   r_r;        // working remainder, starts as the dividend
    logic [W-1:0]   b_r;        // divisor
    logic           dbz_r;
    logic           busy_r;
    logic           done_r;

    logic           ge_s;        // remainder still holds at least one divisor
    logic           abort_hit_s; // cancel request accepted this cycle
    logic           run_s;       // state is one that can be cancelled

    localparam logic [W-1:0] ZERO_W = {W{1'b0}};
    localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};

    // Compare gates the subtraction, so r_r - b_r can never underflow.
    always_comb begin
        ge_s = (r_r >= b_r);
    end

    // Decode the cancellable states and qualify the optional abort request.
    always_comb begin
        run_s = (state_r == ST_LDA) || (state_r == ST_LDB) || (state_r == ST_CALC);
`ifdef DIV_ABORT_EN
        abort_hit_s = abort && run_s;
`else
        abort_hit_s = 1'b0;
`endif
    end

    // Next-state logic for the load / calculate / done sequence.
    always_comb begin
        next_state_s = state_r;
        if (abort_hit_s) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        next_state_s = ST_LDA;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_LDA: begin
                    next_state_s = ST_LDB;
                end
                ST_LDB: begin
                    if (data_in == ZERO_W) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (ge_s) begin
                        next_state_s = ST_CALC;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A held start parks here instead of retriggering.
                    if (start) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath registers: operand loads, subtract/increment, divide-by-zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r   <= ZERO_W;
            r_r   <= ZERO_W;
            b_r   <= ZERO_W;
            dbz_r <= 1'b0;
        end else if (abort_hit_s) begin
            q_r   <= ZERO_W;
            r_r   <= ZERO_W;
            dbz_r <= 1'b0;
        end else begin
            case (state_r)
                ST_LDA: begin
                    r_r   <= data_in;
                    q_r   <= ZERO_W;
                    dbz_r <= 1'b0;
                end
                ST_LDB: begin
                    b_r <= data_in;
                    if (data_in == ZERO_W) begin
                        dbz_r <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (ge_s) begin
                        r_r <= r_r - b_r;
                        q_r <= q_r + ONE_W;
                    end
                end
                default: begin
                    // IDLE and DONE hold the last result.
                end
            endcase
        end
    end

    // Status flags registered from the next state so they track state_r exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s == ST_LDA) || (next_state_s == ST_LDB) ||
                      (next_state_s == ST_CALC);
            done_r <= (next_state_s == ST_DONE);
        end
    end

    assign quotient  = q_r;
    assign remainder = r_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign dbz       = dbz_r;

endmodule

// File: tb/tb_div_repsub.sv
// Self-checking bench for div_repsub: directed cases from the test plan plus
// randomized divisions checked against plain integer division and the
// documented latency (quotient + 4 edges, or 3 edges for divide-by-zero).
// Build with +define+DIV_ABORT_EN to also exercise the abort input.
module tb_div_repsub;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         dbz;
`ifdef DIV_ABORT_EN
    logic         abort;
`endif

    int checks;
    int errors;

    div_repsub #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef DIV_ABORT_EN
        .abort     (abort),
`endif
        .data_in   (data_in),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one division a/b; expectations come from integer arithmetic.
    task automatic do_div(input int unsigned a, input int unsigned b, input bit hold);
        int unsigned exp_q, exp_r, lat, edges, bound;
        bit          exp_dbz, busy_ok;
        exp_dbz = (b == 0);
        exp_q   = exp_dbz ? 0 : a / b;
        exp_r   = exp_dbz ? a : a % b;
        lat     = exp_dbz ? 3 : exp_q + 4;
        bound   = lat + 8;
        busy_ok = 1'b1;

        start = 1'b1; data_in = W'($urandom); step(); edges = 1;
        if (!(busy === 1'b1 && done === 1'b0)) busy_ok = 1'b0;
        data_in = W'(a); start = 1'($urandom); step(); edges = 2;
        if (!(busy === 1'b1 && done === 1'b0)) busy_ok = 1'b0;
        data_in = W'(b); start = 1'($urandom); step(); edges = 3;
        start = 1'b0;
        while (done !== 1'b1 && edges < bound) begin
            if (!(busy === 1'b1)) busy_ok = 1'b0;
            data_in = W'($urandom);
            step();
            edges++;
        end

        checks++;
        if (edges !== lat) begin
            errors++;
            $display("FAIL latency %0d/%0d: got %0d edges, want %0d", a, b, edges, lat);
        end
        checks++;
        if (quotient !== W'(exp_q)) begin
            errors++;
            $display("FAIL quotient %0d/%0d: got %0d, want %0d", a, b, quotient, exp_q);
        end
        checks++;
        if (remainder !== W'(exp_r)) begin
            errors++;
            $display("FAIL remainder %0d/%0d: got %0d, want %0d", a, b, remainder, exp_r);
        end
        checks++;
        if (dbz !== exp_dbz) begin
            errors++;
            $display("FAIL dbz %0d/%0d: got %0b, want %0b", a, b, dbz, exp_dbz);
        end
        checks++;
        if (!busy_ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy %0d/%0d: busy pattern ok=%0b busy_in_done=%0b, want ok=1 busy=0",
                     a, b, busy_ok, busy);
        end

        if (hold) begin
            start = 1'b1;
            for (int i = 0; i < 4; i++) begin
                step();
                checks++;
                if (done !== 1'b1 || busy !== 1'b0 || quotient !== W'(exp_q)) begin
                    errors++;
                    $display("FAIL hold_start: done=%0b busy=%0b q=%0d, want done=1 busy=0 q=%0d",
                             done, busy, quotient, exp_q);
                end
            end
        end
        start = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== W'(exp_q) || remainder !== W'(exp_r)) begin
            errors++;
            $display("FAIL idle_hold %0d/%0d: done=%0b busy=%0b q=%0d r=%0d, want 0 0 %0d %0d",
                     a, b, done, busy, quotient, remainder, exp_q, exp_r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data_in = '0;
        step(); step();
        checks++;
        if (quotient !== '0 || remainder !== '0 || busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL reset: q=%0d r=%0d busy=%0b done=%0b dbz=%0b, want all 0",
                     quotient, remainder, busy, done, dbz);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        do_div(17, 5, 1'b0);
        do_div(5, 17, 1'b0);
        do_div(0, 7, 1'b0);
    endtask

    task automatic test_dbz();
        do_div(100, 0, 1'b0);
        do_div(9, 3, 1'b0);
    endtask

    task automatic test_max();
        do_div(65535, 1, 1'b0);
    endtask

    task automatic test_hold_start();
        do_div(12, 5, 1'b1);
        do_div(8, 2, 1'b0);
    endtask

    task automatic test_random();
        int unsigned a, b, lim;
        for (int n = 0; n < 24; n++) begin
            b   = $urandom_range(1, 400);
            lim = b * 60;
            if (lim > 65535) lim = 65535;
            a   = $urandom_range(0, lim);
            if (n % 6 == 5) b = 0;
            do_div(a, b, 1'b0);
        end
    endtask

    // Start 1000/3 and advance to just before edge 20 (16 subtractions done).
    task automatic start_1000_3();
        start = 1'b1; step();
        start = 1'b0; data_in = 16'd1000; step();
        data_in = 16'd3; step();
        for (int e = 4; e <= 19; e++) step();
        checks++;
        if (busy !== 1'b1 || quotient !== 16'd16 || remainder !== 16'd952) begin
            errors++;
            $display("FAIL mid_calc: busy=%0b q=%0d r=%0d, want 1 16 952", busy, quotient, remainder);
        end
    endtask

    task automatic test_rst_mid();
        start_1000_3();
        rst = 1'b1; step(); rst = 1'b0;
        checks++;
        if (quotient !== '0 || remainder !== '0 || busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: q=%0d r=%0d busy=%0b done=%0b dbz=%0b, want all 0",
                     quotient, remainder, busy, done, dbz);
        end
        step(); step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle: busy=%0b done=%0b, want 0 0", busy, done);
        end
    endtask

`ifdef DIV_ABORT_EN
    task automatic test_abort();
        bit saw_done;
        start_1000_3();
        abort = 1'b1; step(); abort = 1'b0;
        checks++;
        if (quotient !== '0 || remainder !== '0 || busy !== 1'b0 || done !== 1'b0 || dbz !== 1'b0) begin
            errors++;
            $display("FAIL abort: q=%0d r=%0d busy=%0b done=%0b dbz=%0b, want all 0",
                     quotient, remainder, busy, done, dbz);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL abort_quiet: activity seen after abort=%0b, want 0", saw_done);
        end
        do_div(50, 7, 1'b0);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; data_in = '0;
`ifdef DIV_ABORT_EN
        abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_dbz();
        test_hold_start();
        test_rst_mid();
`ifdef DIV_ABORT_EN
        test_abort();
`endif
        test_random();
        test_max();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
